// File: rtl/ppram_responder.sv
// ppram_responder: show-ahead prefetch buffer that streams 64-bit words from a
// request/grant backend. The sequencer pops words from the head. A set_address
// strobe flushes the buffer and restarts the stream at a new word address.
module ppram_responder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pp_ram_set_address,
  input  logic [31:0] pp_ram_address,
  input  logic        pp_ram_read,
  output logic [63:0] pp_ram_data,
  output logic        pp_ram_valid,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [63:0] mem_data_i,
  input  logic        mem_data_valid_i,
  output logic [4:0]  fill_level_o,
  output logic        err_o
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 5;
  // Wide enough for occupancy + live + discard with no overflow.
  localparam int unsigned SUM_W  = 7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic [DATA_W-1:0]   buf_d [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0]    live_q, live_d;
  logic [CNT_W-1:0]    disc_q, disc_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  // Per-cycle events derived from current inputs and registered state.
  logic                gnt_acc;
  logic                resp_disc;
  logic                resp_live;
  logic                resp_err;
  logic                do_push;
  logic                do_pop;
  logic [SUM_W-1:0]    credit_used;

  // Classify this cycle's grant, response and pop events.
  assign gnt_acc   = req_q & mem_gnt_i;
  assign resp_disc = mem_data_valid_i & (disc_q != '0);
  assign resp_live = mem_data_valid_i & (disc_q == '0) & (live_q != '0);
  assign resp_err  = mem_data_valid_i & (disc_q == '0) & (live_q == '0);
  // A set_address flushes the buffer, so a live response that cycle is dropped
  // and a concurrent read is ignored.
  assign do_push   = resp_live & ~pp_ram_set_address;
  assign do_pop    = pp_ram_read & valid_q & ~pp_ram_set_address;

  // Next-state, counter, storage and output computation.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q;
    live_d       = live_q;
    disc_d       = disc_q;
    fetch_addr_d = fetch_addr_q;
    err_d        = err_q;
    req_d        = 1'b0;
    valid_d      = 1'b0;
    credit_used  = '0;

    // Accepted request: count it and advance the fetch address (wraps at 2^32).
    if (gnt_acc) begin
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
    end
    live_d = live_q + CNT_W'(gnt_acc) - CNT_W'(resp_live);
    disc_d = disc_q - CNT_W'(resp_disc);

    if (resp_err) begin
      err_d = 1'b1;
    end

    if (do_push) begin
      buf_d[wr_ptr_q] = mem_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    occ_d = occ_q + CNT_W'(do_push) - CNT_W'(do_pop);

    unique case (state_q)
      ST_IDLE: begin
        if (pp_ram_set_address) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        state_d = ST_STREAM;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Restart: everything still in flight becomes stale and is discarded.
    if (pp_ram_set_address) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      occ_d        = '0;
      disc_d       = disc_d + live_d;
      live_d       = '0;
      fetch_addr_d = pp_ram_address;
    end

    // Request only while buffer space is left for every word already owed.
    credit_used = SUM_W'(occ_d) + SUM_W'(live_d) + SUM_W'(disc_d);
    req_d       = (state_d == ST_STREAM) && (credit_used < SUM_W'(DEPTH));
    valid_d     = (occ_d != '0);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      buf_q        <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      live_q       <= '0;
      disc_q       <= '0;
      fetch_addr_q <= '0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      live_q       <= live_d;
      disc_q       <= disc_d;
      fetch_addr_q <= fetch_addr_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  // Head word is read straight from storage so it is visible with no latency.
  assign pp_ram_data  = buf_q[rd_ptr_q];
  assign pp_ram_valid = valid_q;
  assign mem_req_o    = req_q;
  assign mem_addr_o   = fetch_addr_q;
  assign fill_level_o = occ_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ppram_responder.sv
// Testbench for ppram_responder: directed vector table plus a randomized
// backend/sequencer run checked against a queue-based reference model.
module tb_ppram_responder;

  localparam int unsigned DEPTH = 4;

  logic        clk_i;
  logic        reset_i;
  logic        pp_ram_set_address;
  logic [31:0] pp_ram_address;
  logic        pp_ram_read;
  logic [63:0] pp_ram_data;
  logic        pp_ram_valid;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [63:0] mem_data_i;
  logic        mem_data_valid_i;
  logic [4:0]  fill_level_o;
  logic        err_o;

  ppram_responder #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pp_ram_set_address(pp_ram_set_address),
    .pp_ram_address   (pp_ram_address),
    .pp_ram_read      (pp_ram_read),
    .pp_ram_data      (pp_ram_data),
    .pp_ram_valid     (pp_ram_valid),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_data_i       (mem_data_i),
    .mem_data_valid_i (mem_data_valid_i),
    .fill_level_o     (fill_level_o),
    .err_o            (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backend data pattern: each word identifies its own address.
  function automatic logic [63:0] word(input logic [31:0] a);
    return {~a, a};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        set;
    logic [31:0] addr;
    logic        rd;
    logic        gnt;
    logic        dv;
    logic [63:0] data;
    logic        e_valid;
    logic        e_req;
    logic [31:0] e_addr;
    logic [4:0]  e_fill;
    logic        e_err;
    logic [63:0] e_data;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } out_t;

  out_t        outq[$];
  logic [63:0] exp_buf[$];
  logic        m_stream;
  logic [31:0] m_next;
  int          m_epoch;
  int          cyc;
  int          last_due;

  function automatic logic exp_req();
    return m_stream && ((exp_buf.size() + outq.size()) < DEPTH);
  endfunction

  task automatic model_reset();
    outq.delete();
    exp_buf.delete();
    m_stream = 1'b0;
    m_next   = 32'h0;
    m_epoch  = 0;
    cyc      = 0;
    last_due = -1;
  endtask

  task automatic drive_idle();
    pp_ram_set_address = 1'b0;
    pp_ram_address     = 32'h0;
    pp_ram_read        = 1'b0;
    mem_gnt_i          = 1'b0;
    mem_data_valid_i   = 1'b0;
    mem_data_i         = 64'h0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    model_reset();
    chk("rst.valid", 64'(pp_ram_valid), 64'(0));
    chk("rst.req",   64'(mem_req_o),    64'(0));
    chk("rst.addr",  64'(mem_addr_o),   64'(0));
    chk("rst.fill",  64'(fill_level_o), 64'(0));
    chk("rst.err",   64'(err_o),        64'(0));
    chk("rst.data",  pp_ram_data,       64'(0));
  endtask

  task automatic check_model();
    chk("rnd.req",   64'(mem_req_o),    64'(exp_req()));
    chk("rnd.addr",  64'(mem_addr_o),   64'(m_next));
    chk("rnd.valid", 64'(pp_ram_valid), 64'(exp_buf.size() != 0));
    chk("rnd.fill",  64'(fill_level_o), 64'(exp_buf.size()));
    chk("rnd.err",   64'(err_o),        64'(0));
    if (exp_buf.size() != 0) chk("rnd.data", pp_ram_data, exp_buf[0]);
  endtask

  // One randomized cycle per iteration; model advances on the same edge.
  task automatic run_random(input int cycles, input int gnt_pct, input int rd_pct,
                            input int set_pm, input int max_lat, output int pops);
    logic        do_set, do_rd, do_gnt, do_dv, req_now, had_valid;
    logic [31:0] a;
    out_t        e;
    int          lat, due;
    pops = 0;
    for (int i = 0; i < cycles; i++) begin
      if (n_bad > 100) break;
      check_model();
      req_now = exp_req();
      do_set  = ($urandom_range(999, 0) < set_pm);
      if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
      else                           a = $urandom;
      do_rd   = ($urandom_range(99, 0) < rd_pct);
      do_gnt  = ($urandom_range(99, 0) < gnt_pct);
      do_dv   = (outq.size() != 0) && (outq[0].due <= cyc);
      pp_ram_set_address = do_set;
      pp_ram_address     = a;
      pp_ram_read        = do_rd;
      mem_gnt_i          = do_gnt;
      mem_data_valid_i   = do_dv;
      mem_data_i         = do_dv ? word(outq[0].addr) : {$urandom, $urandom};
      @(posedge clk_i);
      had_valid = (exp_buf.size() != 0);
      if (do_rd && !do_set && had_valid) begin
        void'(exp_buf.pop_front());
        pops++;
      end
      if (do_dv) begin
        e = outq.pop_front();
        if (e.epoch == m_epoch) exp_buf.push_back(word(e.addr));
      end
      if (req_now && do_gnt) begin
        lat = $urandom_range(max_lat, 1);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        outq.push_back('{m_next, m_epoch, due});
        last_due = due;
        m_next   = m_next + 32'd1;
      end
      if (do_set) begin
        m_epoch++;
        exp_buf.delete();
        m_next   = a;
        m_stream = 1'b1;
      end
      cyc++;
      #1;
    end
  endtask

  localparam logic [63:0] D0 = {32'h0000_0001, 32'hFFFF_FFFE};
  localparam logic [63:0] D1 = {32'h0000_0000, 32'hFFFF_FFFF};
  localparam logic [63:0] D2 = {32'hFFFF_FFFF, 32'h0000_0000};
  localparam logic [63:0] D3 = {32'hFFFF_FFFE, 32'h0000_0001};
  localparam logic [63:0] JK = 64'hDEAD_BEEF_0BAD_F00D;

  initial begin
    vec_t v;
    int   p;

    //          rst   set   addr          rd    gnt   dv    data   e_valid e_req e_addr        fill  err   e_data
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 5'd0, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, D0,    1'b1, 1'b1, 32'h0,        5'd1, 1'b0, D0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, D1,    1'b1, 1'b1, 32'h1,        5'd2, 1'b0, D0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, D2,    1'b1, 1'b0, 32'h2,        5'd3, 1'b0, D0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, D3,    1'b1, 1'b0, 32'h2,        5'd4, 1'b0, D0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 32'h2,        5'd4, 1'b0, D0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 32'h2,        5'd3, 1'b0, D1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h3,        5'd3, 1'b0, D1};
    vecs[11] = '{1'b0, 1'b1, 32'h40,       1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'h40,       5'd0, 1'b0, 64'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, JK,    1'b0, 1'b1, 32'h40,       5'd0, 1'b0, 64'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, JK,    1'b0, 1'b1, 32'h40,       5'd0, 1'b1, 64'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 64'h0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, JK,    1'b0, 1'b0, 32'h0,        5'd0, 1'b1, 64'h0};
    vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 64'h0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 64'h0};

    drive_idle();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      reset_i            = v.rst;
      pp_ram_set_address = v.set;
      pp_ram_address     = v.addr;
      pp_ram_read        = v.rd;
      mem_gnt_i          = v.gnt;
      mem_data_valid_i   = v.dv;
      mem_data_i         = v.data;
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d.valid", i), 64'(pp_ram_valid), 64'(v.e_valid));
      chk($sformatf("v%0d.req",   i), 64'(mem_req_o),    64'(v.e_req));
      chk($sformatf("v%0d.addr",  i), 64'(mem_addr_o),   64'(v.e_addr));
      chk($sformatf("v%0d.fill",  i), 64'(fill_level_o), 64'(v.e_fill));
      chk($sformatf("v%0d.err",   i), 64'(err_o),        64'(v.e_err));
      if (v.e_valid || v.rst) chk($sformatf("v%0d.data", i), pp_ram_data, v.e_data);
    end

    // Sustained throughput: always-grant, latency 1, always reading.
    do_reset();
    run_random(1, 100, 0, 1000, 1, p);
    run_random(8, 100, 100, 0, 1, p);
    run_random(40, 100, 100, 0, 1, p);
    chk("throughput.pops", 64'(p), 64'(40));

    // Mixed random traffic with restarts, stalls and variable latency.
    do_reset();
    run_random(1, 60, 50, 1000, 4, p);
    run_random(4000, 60, 50, 15, 4, p);
    run_random(1500, 20, 80, 30, 3, p);
    run_random(1500, 90, 20, 10, 2, p);

    drive_idle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
